// File: rtl/bp_me_stream_lock_arbiter_pkg.sv
// BedRock stream message types, header layout and the beat-count rule shared
// by stream pumps and arbiters so they agree on message length.
package bp_me_stream_lock_arbiter_pkg;

  localparam int unsigned paddr_width_lp  = 40;
  localparam int unsigned mem_type_num_lp = 16;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_pre   = 4'd4,
    e_bedrock_mem_amo   = 4'd5
  } bp_bedrock_mem_type_e;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1   = 3'd0,
    e_bedrock_msg_size_2   = 3'd1,
    e_bedrock_msg_size_4   = 3'd2,
    e_bedrock_msg_size_8   = 3'd3,
    e_bedrock_msg_size_16  = 3'd4,
    e_bedrock_msg_size_32  = 3'd5,
    e_bedrock_msg_size_64  = 3'd6,
    e_bedrock_msg_size_128 = 3'd7
  } bp_bedrock_msg_size_e;

  // Fixed header fields; the payload is appended above these bits.
  typedef struct packed {
    logic [paddr_width_lp-1:0] addr;
    bp_bedrock_msg_size_e      size;
    bp_bedrock_mem_type_e      msg_type;
  } bp_bedrock_hdr_base_s;

  localparam int unsigned bedrock_hdr_base_w = $bits(bp_bedrock_hdr_base_s);
  localparam int unsigned hdr_type_lsb       = 0;
  localparam int unsigned hdr_type_w         = $bits(bp_bedrock_mem_type_e);
  localparam int unsigned hdr_size_lsb       = hdr_type_w;
  localparam int unsigned hdr_size_w         = $bits(bp_bedrock_msg_size_e);

  localparam logic [mem_type_num_lp-1:0] default_stream_mask =
    16'((1 << e_bedrock_mem_wr) | (1 << e_bedrock_mem_uc_wr));

  // Beats in a message: streamed types split by beat width, clamped to one block.
  function automatic int unsigned bp_stream_beats(
    input logic [hdr_type_w-1:0]      msg_type,
    input logic [hdr_size_w-1:0]      size,
    input int unsigned                data_width,
    input int unsigned                block_width,
    input logic [mem_type_num_lp-1:0] mask
  );
    int unsigned n;
    int unsigned max_n;
    max_n = block_width / data_width;
    if (!mask[msg_type]) return 1;
    n = (32'd1 << size) / (data_width / 8);
    if (n == 0) n = 1;
    if (n > max_n) n = max_n;
    return n;
  endfunction

endpackage

// File: rtl/bp_me_stream_beat_counter.sv
// Down-counter of beats remaining in a stream message, with a last-beat flag.
module bp_me_stream_beat_counter #(
  parameter int unsigned cnt_width_p = 3
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   load_i,
  input  logic [cnt_width_p-1:0] load_val_i,
  input  logic                   dec_i,
  output logic                   last_o
);

  logic [cnt_width_p-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - cnt_width_p'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/bp_me_stream_lock_arbiter.sv
// Round-robin arbiter sharing one BedRock stream consumer; the grant is locked
// from the first to the last beat so multi-beat messages never interleave.
module bp_me_stream_lock_arbiter
  import bp_me_stream_lock_arbiter_pkg::*;
#(
  parameter int unsigned num_req_p             = 2,
  parameter int unsigned data_width_p          = 64,
  parameter int unsigned bedrock_block_width_p = 512,
  parameter int unsigned payload_width_p       = 8,
  parameter logic [mem_type_num_lp-1:0] stream_mask_p = default_stream_mask,
  localparam int unsigned hdr_w = payload_width_p + bedrock_hdr_base_w
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [num_req_p*hdr_w-1:0]        msg_header_i,
  input  logic [num_req_p*data_width_p-1:0] msg_data_i,
  input  logic [num_req_p-1:0]              msg_v_i,
  output logic [num_req_p-1:0]              msg_ready_and_o,
  output logic [hdr_w-1:0]                  msg_header_o,
  output logic [data_width_p-1:0]           msg_data_o,
  output logic                              msg_v_o,
  input  logic                              msg_ready_and_i,
  output logic [num_req_p-1:0]              grant_o,
  output logic                              lock_o
);

  localparam int unsigned max_beats_lp = bedrock_block_width_p / data_width_p;
  localparam int unsigned cnt_w_lp     = (max_beats_lp > 1) ? $clog2(max_beats_lp) : 1;
  localparam int unsigned beats_w_lp   = cnt_w_lp + 1;
  localparam int unsigned sel_w_lp     = $clog2(num_req_p);
  localparam int unsigned sum_w_lp     = sel_w_lp + 1;

  localparam logic [0:0] st_idle_lp = 1'b0;
  localparam logic [0:0] st_lock_lp = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [sel_w_lp-1:0] rr_ptr_q, rr_ptr_d;
  logic [sel_w_lp-1:0] lock_grant_q, lock_grant_d;

  logic                  found;
  logic [sel_w_lp-1:0]   winner;
  logic [sum_w_lp-1:0]   rr_sum;
  logic                  gnt_any;
  logic [sel_w_lp-1:0]   gnt_idx;
  logic                  hs;
  logic [beats_w_lp-1:0] beats_c;
  logic                  cnt_load, cnt_dec, cnt_last;

  function automatic logic [sel_w_lp-1:0] rr_next(input logic [sel_w_lp-1:0] idx);
    return (idx == sel_w_lp'(num_req_p - 1)) ? '0 : idx + sel_w_lp'(1);
  endfunction

  // Round-robin pick: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    rr_sum = '0;
    for (int k = 0; k < int'(num_req_p); k++) begin
      rr_sum = {1'b0, rr_ptr_q} + sum_w_lp'(k);
      if (rr_sum >= sum_w_lp'(num_req_p)) rr_sum = rr_sum - sum_w_lp'(num_req_p);
      if (!found && msg_v_i[rr_sum[sel_w_lp-1:0]]) begin
        found  = 1'b1;
        winner = rr_sum[sel_w_lp-1:0];
      end
    end
  end

  // Grant selection and datapath mux; everything is forced quiet while in reset.
  always_comb begin
    gnt_any = found;
    gnt_idx = winner;
    if (state_q == st_lock_lp) begin
      gnt_any = 1'b1;
      gnt_idx = lock_grant_q;
    end
    if (!reset_n_i) gnt_any = 1'b0;
    grant_o = '0;
    if (gnt_any) grant_o[gnt_idx] = 1'b1;
    msg_v_o         = gnt_any & msg_v_i[gnt_idx];
    msg_header_o    = msg_header_i[gnt_idx*hdr_w +: hdr_w];
    msg_data_o      = msg_data_i[gnt_idx*data_width_p +: data_width_p];
    msg_ready_and_o = {num_req_p{msg_ready_and_i}} & grant_o;
  end

  assign hs     = msg_v_o & msg_ready_and_i;
  assign lock_o = (state_q == st_lock_lp);
  assign beats_c = beats_w_lp'(bp_stream_beats(
    msg_header_o[hdr_type_lsb +: hdr_type_w],
    msg_header_o[hdr_size_lsb +: hdr_size_w],
    data_width_p, bedrock_block_width_p, stream_mask_p));

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    lock_grant_d = lock_grant_q;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    if (hs) begin
      if (state_q == st_idle_lp) begin
        if (beats_c > beats_w_lp'(1)) begin
          state_d      = st_lock_lp;
          lock_grant_d = winner;
          cnt_load     = 1'b1;
        end else begin
          rr_ptr_d = rr_next(winner);
        end
      end else if (cnt_last) begin
        state_d  = st_idle_lp;
        rr_ptr_d = rr_next(lock_grant_q);
      end else begin
        cnt_dec = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= st_idle_lp;
      rr_ptr_q     <= '0;
      lock_grant_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      lock_grant_q <= lock_grant_d;
    end
  end

  bp_me_stream_beat_counter #(
    .cnt_width_p(cnt_w_lp)
  ) u_beat_counter (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .load_i     (cnt_load),
    .load_val_i (cnt_w_lp'(beats_c - beats_w_lp'(2))),
    .dec_i      (cnt_dec),
    .last_o     (cnt_last)
  );

endmodule

// File: tb/tb_bp_me_stream_lock_arbiter.sv
// Directed bench for the stream lock arbiter: per-port message feeders, a
// message-level reference model compared every cycle, and literal beat logs.
module tb_bp_me_stream_lock_arbiter;
  import bp_me_stream_lock_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int BW = 512;
  localparam int PW = 8;
  localparam int HW = PW + bedrock_hdr_base_w;
  localparam logic [15:0] MASK = 16'h000A;  // mem_wr and mem_uc_wr stream

  typedef struct {
    int          port;
    logic        lock;
    logic [63:0] data;
    int          cyc;
  } log_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic rdy = 1'b1;
  logic [N-1:0] drv_v = '0;
  logic [N-1:0] gap = '0;
  logic [N-1:0] v_in;
  logic [N-1:0] fire_q = '0;
  logic [HW-1:0] hdr_in[N];
  logic [DW-1:0] data_in[N];
  logic [N*HW-1:0] hdr_pk;
  logic [N*DW-1:0] data_pk;

  logic [N-1:0]  msg_ready_and_o;
  logic [HW-1:0] msg_header_o;
  logic [DW-1:0] msg_data_o;
  logic          msg_v_o;
  logic [N-1:0]  grant_o;
  logic          lock_o;

  logic [HW-1:0] mq[N][$];
  int beat_idx[N] = '{default: 0};
  int msg_seq[N]  = '{default: 0};
  log_t lg[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model state: message-level view of who owns the consumer.
  bit m_locked = 0;
  int m_owner  = 0;
  int m_left   = 0;
  int m_ptr    = 0;

  bp_me_stream_lock_arbiter #(
    .num_req_p(N), .data_width_p(DW), .bedrock_block_width_p(BW),
    .payload_width_p(PW), .stream_mask_p(MASK)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .msg_header_i(hdr_pk), .msg_data_i(data_pk), .msg_v_i(v_in),
    .msg_ready_and_o(msg_ready_and_o),
    .msg_header_o(msg_header_o), .msg_data_o(msg_data_o), .msg_v_o(msg_v_o),
    .msg_ready_and_i(rdy), .grant_o(grant_o), .lock_o(lock_o)
  );

  always #5 clk = ~clk;

  assign v_in = drv_v & ~gap;

  always_comb begin
    hdr_pk  = '0;
    data_pk = '0;
    for (int i = 0; i < N; i++) begin
      hdr_pk[i*HW +: HW]  = hdr_in[i];
      data_pk[i*DW +: DW] = data_in[i];
    end
  end

  function automatic int tb_beats(input logic [HW-1:0] h);
    int n;
    logic [3:0] t;
    logic [2:0] s;
    t = h[3:0];
    s = h[6:4];
    if (!MASK[t]) return 1;
    n = (1 << s) / (DW / 8);
    if (n < 1) n = 1;
    if (n > BW / DW) n = BW / DW;
    return n;
  endfunction

  function automatic logic [HW-1:0] make_hdr(input int p, input bp_bedrock_mem_type_e t,
                                             input bp_bedrock_msg_size_e s);
    bp_bedrock_hdr_base_s b;
    b          = '0;
    b.msg_type = t;
    b.size     = s;
    b.addr     = 40'(p) << 6;
    return {8'(p), b};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_log(input string nm, input int idx, input int port, input logic lock);
    if (idx >= lg.size()) begin
      checks++;
      failures++;
      $display("FAIL %s missing beat %0d (have %0d)", nm, idx, lg.size());
    end else begin
      chk($sformatf("%s_port%0d", nm, idx), 64'(lg[idx].port), 64'(port));
      chk($sformatf("%s_lock%0d", nm, idx), 64'(lg[idx].lock), 64'(lock));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_log(input int n, input string nm);
    int b;
    b = 0;
    while (lg.size() < n && b < 200) begin
      tick();
      b++;
    end
    chk({nm, "_timeout"}, 64'(lg.size() >= n), 64'(1));
  endtask

  task automatic push(input int p, input bp_bedrock_mem_type_e t, input bp_bedrock_msg_size_e s);
    mq[p].push_back(make_hdr(p, t, s));
  endtask

  // Per-port feeders: present the head message beat by beat, advancing on handshake.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (fire_q[i] && mq[i].size() != 0) begin
        beat_idx[i]++;
        if (beat_idx[i] >= tb_beats(mq[i][0])) begin
          void'(mq[i].pop_front());
          beat_idx[i] = 0;
          msg_seq[i]++;
        end
      end
      if (mq[i].size() == 0) begin
        drv_v[i]    = 1'b0;
        beat_idx[i] = 0;
      end else begin
        drv_v[i]   = 1'b1;
        hdr_in[i]  = mq[i][0];
        data_in[i] = {8'(i), 24'(msg_seq[i]), 24'h0, 8'(beat_idx[i])};
      end
    end
  end

  // Per-cycle comparison of the DUT against the message-level model.
  always @(negedge clk) begin
    int g;
    int ap;
    bit ev;
    logic [N-1:0] eg;
    cyc++;
    fire_q = v_in & msg_ready_and_o;
    if (!rst_n) begin
      m_locked = 0;
      m_ptr    = 0;
      m_left   = 0;
      chk("rst_grant", 64'(grant_o), 64'(0));
      chk("rst_v", 64'(msg_v_o), 64'(0));
      chk("rst_lock", 64'(lock_o), 64'(0));
      chk("rst_ready", 64'(msg_ready_and_o), 64'(0));
    end else begin
      g = -1;
      if (m_locked) g = m_owner;
      else
        for (int k = 0; k < N; k++)
          if (g < 0 && v_in[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      eg = '0;
      if (g >= 0) eg[g] = 1'b1;
      ev = (g >= 0) && v_in[g];
      chk("grant", 64'(grant_o), 64'(eg));
      chk("valid", 64'(msg_v_o), 64'(ev));
      chk("lock", 64'(lock_o), 64'(m_locked));
      chk("ready", 64'(msg_ready_and_o), 64'(rdy ? eg : '0));
      if (ev) begin
        chk("header", 64'(msg_header_o), 64'(hdr_in[g]));
        chk("data", 64'(msg_data_o), 64'(data_in[g]));
      end
      if (ev && rdy) begin
        ap = -1;
        for (int i = 0; i < N; i++) if (grant_o[i]) ap = (ap < 0) ? i : -2;
        lg.push_back('{port: ap, lock: lock_o, data: 64'(msg_data_o), cyc: cyc});
        if (!m_locked) begin
          if (tb_beats(hdr_in[g]) > 1) begin
            m_locked = 1;
            m_owner  = g;
            m_left   = tb_beats(hdr_in[g]) - 1;
          end else begin
            m_ptr = (g + 1) % N;
          end
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_locked = 0;
            m_ptr    = (g + 1) % N;
          end
        end
      end
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    // Outputs stay quiet in reset even with a requester valid.
    push(2, e_bedrock_mem_rd, e_bedrock_msg_size_8);
    tick(); tick(); tick();
    chk("reset_grant", 64'(grant_o), 64'(0));
    chk("reset_v", 64'(msg_v_o), 64'(0));
    chk("reset_lock", 64'(lock_o), 64'(0));
    mq[2].delete();
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single requester: three back-to-back single-beat reads.
    lg.delete();
    for (int i = 0; i < 3; i++) push(0, e_bedrock_mem_rd, e_bedrock_msg_size_8);
    wait_log(3, "single");
    for (int i = 0; i < 3; i++) chk_log("single", i, 0, 1'b0);
    if (lg.size() >= 3) chk("single_b2b", 64'(lg[2].cyc - lg[0].cyc), 64'(2));

    // Lock held: 8-beat write on port 0 while port 1 is continuously valid.
    lg.delete();
    push(0, e_bedrock_mem_wr, e_bedrock_msg_size_64);
    tick();
    push(1, e_bedrock_mem_rd, e_bedrock_msg_size_8);
    push(1, e_bedrock_mem_rd, e_bedrock_msg_size_8);
    wait_log(10, "lockheld");
    for (int i = 0; i < 8; i++) chk_log("lockheld", i, 0, (i != 0));
    chk_log("lockheld", 8, 1, 1'b0);
    chk_log("lockheld", 9, 1, 1'b0);
    if (lg.size() >= 8) chk("lockheld_beat7", lg[7].data[7:0], 64'(7));

    // Fairness: steer rr_ptr to 0, then all four ports contend.
    push(3, e_bedrock_mem_rd, e_bedrock_msg_size_8);
    lg.delete();
    wait_log(1, "fair_pre");
    lg.delete();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < N; p++) push(p, e_bedrock_mem_rd, e_bedrock_msg_size_8);
    wait_log(8, "fair");
    for (int i = 0; i < 8; i++) chk_log("fair", i, i % N, 1'b0);

    // Stall and gap inside a 4-beat lock on port 2, port 1 waiting.
    lg.delete();
    push(2, e_bedrock_mem_uc_wr, e_bedrock_msg_size_32);
    tick();
    push(1, e_bedrock_mem_rd, e_bedrock_msg_size_8);
    wait_log(2, "stall_pre");
    rdy = 1'b0;
    tick(); tick();
    rdy = 1'b1;
    gap[2] = 1'b1;
    #1;
    chk("gap_grant", 64'(grant_o), 64'(4'b0100));
    chk("gap_v", 64'(msg_v_o), 64'(0));
    chk("gap_lock", 64'(lock_o), 64'(1));
    tick();
    gap[2] = 1'b0;
    wait_log(5, "stall");
    for (int i = 0; i < 4; i++) begin
      chk_log("stall", i, 2, (i != 0));
      if (lg.size() > i) chk($sformatf("stall_beat%0d", i), lg[i].data[7:0], 64'(i));
    end
    chk_log("stall", 4, 1, 1'b0);

    // Reset after beat 3 of an 8-beat message.
    lg.delete();
    push(0, e_bedrock_mem_wr, e_bedrock_msg_size_64);
    wait_log(3, "midrst_pre");
    chk("midrst_locked", 64'(lock_o), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("midrst_v", 64'(msg_v_o), 64'(0));
    chk("midrst_lock", 64'(lock_o), 64'(0));
    chk("midrst_grant", 64'(grant_o), 64'(0));
    mq[0].delete();
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("postrst_grant0", 64'(grant_o), 64'(0));
    tick();
    chk("postrst_grant1", 64'(grant_o), 64'(0));
    lg.delete();
    push(3, e_bedrock_mem_rd, e_bedrock_msg_size_8);
    push(0, e_bedrock_mem_rd, e_bedrock_msg_size_8);
    wait_log(2, "postrst");
    chk_log("postrst", 0, 0, 1'b0);
    chk_log("postrst", 1, 3, 1'b0);

    // Unmasked 64B read and a beat-sized uc write are single-beat.
    lg.delete();
    push(1, e_bedrock_mem_rd, e_bedrock_msg_size_64);
    push(2, e_bedrock_mem_rd, e_bedrock_msg_size_8);
    push(3, e_bedrock_mem_uc_wr, e_bedrock_msg_size_8);
    wait_log(3, "unmasked");
    chk_log("unmasked", 0, 1, 1'b0);
    chk_log("unmasked", 1, 2, 1'b0);
    chk_log("unmasked", 2, 3, 1'b0);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
